lzc_norm_pipe: RTL and testbench
================================

// Module: lzc_norm_pipe
// PURPOSE
//  Parametrised, pipelined leading-zero counter with optional normalising left shift.
//  Successor to the fixed 24-bit combinational LZ encoder used in the IEEE add/sub datapath.
//  Adds a generic WIDTH, an explicit all-zero flag (count = WIDTH) and a 2-stage pipeline
//    with valid/ready backpressure, so the post-subtract normalise step can be retimed.
// PARAMETERS
//  WIDTH  24  input mantissa width in bits; must be >= 2
//  SEG_W  8   stage-1 segment width; WIDTH % SEG_W == 0; NSEG = WIDTH/SEG_W
//  CW     $clog2(WIDTH+1)  count width (localparam, not overridable)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      input word present
//  in_ready   out  1      block accepts in_data this cycle
//  in_data    in   WIDTH  operand; MSB is bit WIDTH-1
//  out_valid  out  1      result present
//  out_ready  in   1      downstream accepts result this cycle
//  out_count  out  CW     leading zeros of the accepted word, 0..WIDTH
//  out_zero   out  1      1 iff accepted word was all zero
//  out_norm   out  WIDTH  in_data << out_count (only with LZC_NORM_EN)
// BEHAVIOUR
//  One clock (clk); reset is synchronous and active-high (rst).
//  Reset: s1_v=0, s2_v=0, out_valid=0, out_count=0, out_zero=0, out_norm=0; data regs cleared.
//  Handshake: transfer on valid&&ready at a rising edge; in_valid/out_valid never depend on own ready.
//  Once out_valid=1, out_count/out_zero/out_norm are held stable until out_ready=1.
//  Stage enables (combinational):
//    s2_ld = !s2_v || out_ready;  s1_ld = !s1_v || s2_ld;  in_ready = s1_ld.
//  Stage 1 (on s1_ld): s1_v <= in_valid; if in_valid, register in_data and per-segment results:
//    seg_nz[i] = |seg[i]; seg_lz[i] = leading zeros within segment i (0..SEG_W-1 when nz).
//    Segment NSEG-1 is the most significant.
//  Stage 2 (on s2_ld): s2_v <= s1_v; if s1_v:
//    k = index of first nonzero segment from MSB; count = (NSEG-1-k)*SEG_W + seg_lz[k].
//    No nonzero segment: count = WIDTH, zero = 1; else zero = 0.
//  out_valid = s2_v. Latency: 2 cycles from accept to out_valid with out_ready held high.
//  Throughput 1 word/cycle with out_ready high; bubbles collapse (s1 refills while s2 stalls).
//  Full: s1_v && s2_v && !out_ready -> in_ready=0; no word dropped, duplicated or reordered.
//  Simultaneous out accept and in accept in same cycle: both occur; occupancy unchanged.
//  in_ready combinationally depends on out_ready (one-gate path); no other comb in->out paths.
//  rst mid-stream: both stages emptied next edge, in-flight words discarded, in_ready=1 after.
//  Arithmetic: all counts unsigned CW bits; no saturation needed since max is WIDTH.
// CONFIGURATION
//  LZC_NORM_EN defined: stage 2 also performs barrel shift out_norm = s1_data << count
//    (log2 mux levels); all-zero input yields out_norm = 0; out_norm held while stalled.
//  LZC_NORM_EN undefined: no shifter, out_norm port absent; count/zero/handshake identical.
// TESTING (WIDTH=24, SEG_W=8, out_ready=1 unless stated)
//  24'h800000 -> out_count=0, out_zero=0, out_norm=24'h800000, out_valid 2 cycles after accept.
//  24'h000001 -> out_count=23, out_zero=0, out_norm=24'h800000.
//  24'h000000 -> out_count=24, out_zero=1, out_norm=24'h000000.
//  24'h00F000 then 24'h000080 back-to-back -> counts 8 then 16, norms F00000/800000, consecutive cycles.
//  out_ready=0 for 6 cycles, in_valid=1 with 3 words -> 2 accepted, in_ready=0, out held; release -> 3 in order.
//  rst asserted 1 cycle with both stages full -> out_valid=0 next cycle, no stale word emitted later.
//  Random sweep 10k words with random out_ready, both macro settings -> matches priority-encoder model.

Source files
------------

// File: rtl/lzc_norm_pipe.sv
// Two-stage leading-zero counter: stage 1 gets per-segment LZ, stage 2 picks the first nonzero segment.
// Define LZC_NORM_EN to add the normalising left shift and the out_norm port.
module lzc_norm_pipe #(
    parameter int WIDTH = 24,
    parameter int SEG_W = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
`ifdef LZC_NORM_EN
    output logic [WIDTH-1:0] out_norm,
`endif
    output logic             out_zero
);
    localparam int NSEG = WIDTH / SEG_W;
    localparam int LW   = (SEG_W > 1) ? $clog2(SEG_W) : 1;

    logic            w_s1_ld;
    logic            w_s2_ld;
    logic            r_s1_v;
    logic            r_s2_v;
    logic [NSEG-1:0] w_seg_nz;
    logic [NSEG-1:0] r_seg_nz;
    logic [LW-1:0]   w_seg_lz [NSEG];
    logic [LW-1:0]   r_seg_lz [NSEG];
    logic [CW-1:0]   w_count;
    logic            w_zero;
    logic [CW-1:0]   r_count;
    logic            r_zero;

    // Each stage may load when it is empty or its content is leaving this cycle.
    assign w_s2_ld   = !r_s2_v || out_ready;
    assign w_s1_ld   = !r_s1_v || w_s2_ld;
    assign in_ready  = w_s1_ld;
    assign out_valid = r_s2_v;
    assign out_count = r_count;
    assign out_zero  = r_zero;

    always_comb begin
        for (int i = 0; i < NSEG; i++) begin
            w_seg_nz[i] = |in_data[i*SEG_W +: SEG_W];
            w_seg_lz[i] = '0;
            // Scanning upward means the highest set bit wins.
            for (int j = 0; j < SEG_W; j++) begin
                if (in_data[i*SEG_W + j]) w_seg_lz[i] = LW'(SEG_W - 1 - j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v   <= 1'b0;
            r_seg_nz <= '0;
            for (int i = 0; i < NSEG; i++) r_seg_lz[i] <= '0;
        end else if (w_s1_ld) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_seg_nz <= w_seg_nz;
                for (int i = 0; i < NSEG; i++) r_seg_lz[i] <= w_seg_lz[i];
            end
        end
    end

    always_comb begin
        w_count = CW'(WIDTH);
        w_zero  = 1'b1;
        for (int i = 0; i < NSEG; i++) begin
            if (r_seg_nz[i]) begin
                w_count = CW'((NSEG - 1 - i) * SEG_W) + CW'(r_seg_lz[i]);
                w_zero  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_v  <= 1'b0;
            r_count <= '0;
            r_zero  <= 1'b0;
        end else if (w_s2_ld) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_count <= w_count;
                r_zero  <= w_zero;
            end
        end
    end

`ifdef LZC_NORM_EN
    logic [WIDTH-1:0] r_s1_data;
    logic [WIDTH-1:0] w_sh [CW+1];
    logic [WIDTH-1:0] r_norm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_data <= '0;
        end else if (w_s1_ld && in_valid) begin
            r_s1_data <= in_data;
        end
    end

    // Log-depth barrel shifter; a count of WIDTH only occurs for zero data.
    always_comb begin
        w_sh[0] = r_s1_data;
        for (int b = 0; b < CW; b++) begin
            w_sh[b+1] = w_count[b] ? (w_sh[b] << (2 ** b)) : w_sh[b];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_norm <= '0;
        end else if (w_s2_ld && r_s1_v) begin
            r_norm <= w_sh[CW];
        end
    end

    assign out_norm = r_norm;
`endif
endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Randomised and directed bench for lzc_norm_pipe (WIDTH=24, SEG_W=8) against a queue-based model.
module tb_lzc_norm_pipe;
    localparam int W  = 24;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_count;
    logic          out_zero;
    logic [W-1:0]  out_norm;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] q[$];
    logic          s_fin, s_fout, s_irdy, s_ovld, s_zero, s_qempty;
    logic [CW-1:0] s_cnt;
    logic [W-1:0]  s_norm, s_src;

    lzc_norm_pipe #(.WIDTH(24), .SEG_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count),
`ifdef LZC_NORM_EN
        .out_norm(out_norm),
`endif
        .out_zero(out_zero)
    );

`ifndef LZC_NORM_EN
    assign out_norm = '0;
`endif

    always #5 clk = ~clk;

    function automatic int ref_lz(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--) if (d[i]) return W - 1 - i;
        return W;
    endfunction

    function automatic logic [W-1:0] ref_norm(input logic [W-1:0] d);
        if (d == '0) return '0;
        return d << ref_lz(d);
    endfunction

    // Drive one cycle, sample away from the edge, update the model at the edge.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy);
        @(negedge clk);
        in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        s_irdy = in_ready; s_ovld = out_valid;
        s_cnt = out_count; s_zero = out_zero; s_norm = out_norm;
        s_fin = iv && in_ready; s_fout = out_valid && ordy;
        s_qempty = (q.size() == 0);
        s_src = '0;
        if (s_fout && !s_qempty) s_src = q.pop_front();
        if (s_fin) q.push_back(d);
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_count !== '0 || out_zero !== 1'b0) begin failures++; $display("FAIL reset_outputs count=%0d zero=%b exp 0/0", out_count, out_zero); end
`ifdef LZC_NORM_EN
        checks++; if (out_norm !== '0) begin failures++; $display("FAIL reset_norm got=%h exp=0", out_norm); end
`endif
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_directed;
        logic [W-1:0] vec [3];
        vec[0] = 24'h800000; vec[1] = 24'h000001; vec[2] = 24'h000000;
        for (int v = 0; v < 3; v++) begin
            int lat;
            step(1'b1, vec[v], 1'b1);
            checks++; if (s_fin !== 1'b1) begin failures++; $display("FAIL dir_accept[%0d] got=%b exp=1", v, s_fin); end
            lat = 0;
            do begin
                step(1'b0, '0, 1'b1);
                lat++;
            end while (!s_fout && lat < 10);
            checks++; if (lat != 2) begin failures++; $display("FAIL dir_latency[%0d] got=%0d exp=2", v, lat); end
            checks++; if (s_cnt !== CW'(ref_lz(vec[v])) || s_zero !== (vec[v] == '0)) begin
                failures++; $display("FAIL dir_count[%0d] got=%0d/%b exp=%0d/%b", v, s_cnt, s_zero, ref_lz(vec[v]), vec[v] == '0); end
`ifdef LZC_NORM_EN
            checks++; if (s_norm !== ref_norm(vec[v])) begin failures++; $display("FAIL dir_norm[%0d] got=%h exp=%h", v, s_norm, ref_norm(vec[v])); end
`endif
        end
    endtask

    task automatic test_back_to_back;
        int cyc [2];
        int n = 0;
        step(1'b1, 24'h00F000, 1'b1);
        step(1'b1, 24'h000080, 1'b1);
        for (int c = 0; c < 8; c++) begin
            step(1'b0, '0, 1'b1);
            if (s_fout && n < 2) begin
                cyc[n] = c;
                checks++; if (s_cnt !== CW'(ref_lz(s_src)) || s_qempty) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", n, s_cnt, ref_lz(s_src)); end
`ifdef LZC_NORM_EN
                checks++; if (s_norm !== ref_norm(s_src)) begin failures++; $display("FAIL b2b_norm[%0d] got=%h exp=%h", n, s_norm, ref_norm(s_src)); end
`endif
                n++;
            end
        end
        checks++; if (n != 2 || cyc[1] != cyc[0] + 1) begin failures++; $display("FAIL b2b_consecutive got_n=%0d exp=2 consecutive", n); end
    endtask

    task automatic test_stall;
        logic [W-1:0] w [3];
        logic [W-1:0] exp_order [3];
        logic [CW-1:0] hold_cnt;
        logic [W-1:0] hold_norm;
        int idx = 0;
        int got = 0;
        int guard = 0;
        bit held = 0;
        w[0] = 24'h000400; w[1] = 24'h3FFFFF; w[2] = 24'h000000;
        exp_order = w;
        for (int c = 0; c < 6; c++) begin
            step(idx < 3, w[idx < 3 ? idx : 0], 1'b0);
            if (s_fin) idx++;
            if (s_ovld && !held) begin held = 1; hold_cnt = s_cnt; hold_norm = s_norm; end
            else if (held) begin
                checks++; if (!s_ovld || s_cnt !== hold_cnt || s_norm !== hold_norm) begin
                    failures++; $display("FAIL stall_hold got=%b/%0d exp=1/%0d", s_ovld, s_cnt, hold_cnt); end
            end
        end
        checks++; if (idx != 2) begin failures++; $display("FAIL stall_accepted got=%0d exp=2", idx); end
        checks++; if (s_irdy !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", s_irdy); end
        while (got < 3 && guard < 20) begin
            step(idx < 3, w[idx < 3 ? idx : 0], 1'b1);
            if (s_fin) idx++;
            if (s_fout) begin
                checks++; if (s_src !== exp_order[got] || s_cnt !== CW'(ref_lz(exp_order[got]))) begin
                    failures++; $display("FAIL stall_order[%0d] got=%0d exp=%0d", got, s_cnt, ref_lz(exp_order[got])); end
                got++;
            end
            guard++;
        end
        checks++; if (got != 3) begin failures++; $display("FAIL stall_drain got=%0d exp=3", got); end
    endtask

    task automatic test_midstream_reset;
        step(1'b1, 24'h001234, 1'b0);
        step(1'b1, 24'h00ABCD, 1'b0);
        step(1'b0, '0, 1'b0);
        checks++; if (!(s_ovld && !s_irdy)) begin failures++; $display("FAIL mrst_full ovld=%b irdy=%b exp=1/0", s_ovld, s_irdy); end
        @(negedge clk); rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        q.delete();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mrst_after ovld=%b irdy=%b exp=0/1", out_valid, in_ready); end
        for (int c = 0; c < 5; c++) begin
            step(1'b0, '0, 1'b1);
            checks++; if (s_ovld !== 1'b0) begin failures++; $display("FAIL mrst_stale cycle=%0d got=%b exp=0", c, s_ovld); end
        end
    endtask

    task automatic test_random;
        int sent = 0, recv = 0, cyc = 0;
        logic [W-1:0] d;
        logic p_ovld = 0, p_ordy = 1;
        logic [CW-1:0] p_cnt = '0;
        logic [W-1:0] p_norm = '0;
        logic p_zero = 0;
        while (recv < 10000 && cyc < 60000) begin
            logic iv, ordy;
            int exp_irdy;
            d = W'($urandom) >> $urandom_range(0, W);
            iv = (sent < 10000) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            exp_irdy = (q.size() < 2) || ordy;
            step(iv, d, ordy);
            cyc++;
            if (s_fin) sent++;
            checks++; if (s_irdy !== exp_irdy[0]) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, s_irdy, exp_irdy[0]); end
            if (p_ovld && !p_ordy) begin
                checks++; if (!s_ovld || s_cnt !== p_cnt || s_zero !== p_zero || s_norm !== p_norm) begin
                    failures++; $display("FAIL rnd_hold cyc=%0d got=%b/%0d exp=1/%0d", cyc, s_ovld, s_cnt, p_cnt); end
            end
            if (s_fout) begin
                recv++;
                checks++; if (s_qempty || s_cnt !== CW'(ref_lz(s_src)) || s_zero !== (s_src == '0)) begin
                    failures++; $display("FAIL rnd_count word=%0d data=%h got=%0d/%b exp=%0d/%b", recv, s_src, s_cnt, s_zero, ref_lz(s_src), s_src == '0); end
`ifdef LZC_NORM_EN
                checks++; if (s_norm !== ref_norm(s_src)) begin failures++; $display("FAIL rnd_norm word=%0d got=%h exp=%h", recv, s_norm, ref_norm(s_src)); end
`endif
            end
            p_ovld = s_ovld; p_ordy = ordy; p_cnt = s_cnt; p_zero = s_zero; p_norm = s_norm;
        end
        checks++; if (recv != 10000) begin failures++; $display("FAIL rnd_complete got=%0d exp=10000", recv); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_stall;
        test_midstream_reset;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
